// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one combinational ULA between two requesters.
// Fixed IDLE -> EXEC -> RESP sequence with registered operands and captured result.
module ula_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_opcode,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_opcode,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_flag,
    output logic [WIDTH-1:0] ula_a,
    output logic [WIDTH-1:0] ula_b,
    output logic [OPW-1:0]   ula_opcode,
    input  logic [WIDTH-1:0] ula_out,
    input  logic             ula_flag,
    output logic             busy,
    output logic [15:0]      ops_done
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] ula_a_q, ula_a_d;
    logic [WIDTH-1:0] ula_b_q, ula_b_d;
    logic [OPW-1:0]   ula_op_q, ula_op_d;
    logic [WIDTH-1:0] rsp_out_q, rsp_out_d;
    logic             rsp_flag_q, rsp_flag_d;
    logic [15:0]      ops_done_q, ops_done_d;
    logic             grant;

    // Under contention the requester that did not win last time is granted.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ~last_q;
        end else begin
            grant = req1_valid;
        end
    end

    assign req0_ready = (state_q == IDLE) && !grant && req0_valid;
    assign req1_ready = (state_q == IDLE) &&  grant && req1_valid;
    assign rsp0_valid = (state_q == RESP) && !owner_q;
    assign rsp1_valid = (state_q == RESP) &&  owner_q;
    assign busy       = (state_q != IDLE);
    assign rsp_out    = rsp_out_q;
    assign rsp_flag   = rsp_flag_q;
    assign ula_a      = ula_a_q;
    assign ula_b      = ula_b_q;
    assign ula_opcode = ula_op_q;
    assign ops_done   = ops_done_q;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        ula_a_d    = ula_a_q;
        ula_b_d    = ula_b_q;
        ula_op_d   = ula_op_q;
        rsp_out_d  = rsp_out_q;
        rsp_flag_d = rsp_flag_q;
        ops_done_d = ops_done_q;
        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    ula_a_d  = grant ? req1_a      : req0_a;
                    ula_b_d  = grant ? req1_b      : req0_b;
                    ula_op_d = grant ? req1_opcode : req0_opcode;
                    owner_d  = grant;
                    last_d   = grant;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_out_d  = ula_out;
                rsp_flag_d = ula_flag;
                state_d    = RESP;
            end
            RESP: begin
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    ops_done_d = ops_done_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            ula_a_q    <= '0;
            ula_b_q    <= '0;
            ula_op_q   <= '0;
            rsp_out_q  <= '0;
            rsp_flag_q <= 1'b0;
            ops_done_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            ula_a_q    <= ula_a_d;
            ula_b_q    <= ula_b_d;
            ula_op_q   <= ula_op_d;
            rsp_out_q  <= rsp_out_d;
            rsp_flag_q <= rsp_flag_d;
            ops_done_q <= ops_done_d;
        end
    end

endmodule

// File: tb/tb_ula_arbiter.sv
// Scoreboard bench for ula_arbiter with a small behavioural ULA attached.
module tb_ula_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_opcode, req1_opcode;
    logic [31:0] rsp_out, ula_a, ula_b, ula_out;
    logic        rsp_flag, ula_flag, busy;
    logic [4:0]  ula_opcode;
    logic [15:0] ops_done;

    typedef struct {
        logic        id;
        logic [31:0] out;
        logic        flag;
    } exp_t;
    exp_t sb[$];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    ula_arbiter #(.WIDTH(32), .OPW(5)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_opcode(req0_opcode),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_opcode(req1_opcode),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_out(rsp_out), .rsp_flag(rsp_flag),
        .ula_a(ula_a), .ula_b(ula_b), .ula_opcode(ula_opcode),
        .ula_out(ula_out), .ula_flag(ula_flag),
        .busy(busy), .ops_done(ops_done)
    );

    // Behavioural ULA: add, sub, and, signed less-than; zero flag.
    always_comb begin
        case (ula_opcode)
            5'b00000: ula_out = ula_a + ula_b;
            5'b00101: ula_out = ula_a - ula_b;
            5'b10001: ula_out = ula_a & ula_b;
            5'b11111: ula_out = {31'd0, $signed(ula_a) < $signed(ula_b)};
            default:  ula_out = ula_a ^ ula_b;
        endcase
        ula_flag = (ula_out == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic id, input logic [31:0] out);
        exp_t e;
        e.id   = id;
        e.out  = out;
        e.flag = (out == 32'd0);
        sb.push_back(e);
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((sb.size() != 0 || busy) && n < 50) begin
            tick();
            n++;
        end
        chk("drain_timeout", n < 50, 1);
    endtask

    task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] op, input logic [31:0] exp_out);
        int unsigned n = 0;
        push(id, exp_out);
        if (!id) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_opcode = op;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_opcode = op;
        end
        #1;
        while (!(req0_ready || req1_ready) && n < 20) begin
            tick();
            n++;
        end
        chk("accept_timeout", n < 20, 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();
    endtask

    // Response monitor: every completed response handshake pops one expectation.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            chk("one_rsp_valid", {31'd0, rsp0_valid & rsp1_valid}, 0);
            chk("one_req_ready", {31'd0, req0_ready & req1_ready}, 0);
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_rsp", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_owner", {31'd0, rsp1_valid}, {31'd0, e.id});
                    chk("rsp_out", rsp_out, e.out);
                    chk("rsp_flag", {31'd0, rsp_flag}, {31'd0, e.flag});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned accepts;
        int unsigned cyc;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_opcode = '0;
        req1_a = '0; req1_b = '0; req1_opcode = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 0);
        chk("rst_ula_a", ula_a, 0);
        chk("rst_rsp_out", rsp_out, 0);
        chk("rst_ops_done", {16'd0, ops_done}, 0);
        rst = 1'b0;

        // Single op with cycle-accurate latency checks
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_opcode = 5'b00000;
        push(1'b0, 32'd3);
        #1;
        chk("single_ready_c0", {31'd0, req0_ready}, 1);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("single_ula_a_c1", ula_a, 1);
        chk("single_ula_b_c1", ula_b, 2);
        chk("single_busy_c1", {31'd0, busy}, 1);
        chk("single_no_rsp_c1", {31'd0, rsp0_valid}, 0);
        tick();
        chk("single_rsp_valid_c2", {31'd0, rsp0_valid}, 1);
        chk("single_rsp_out_c2", rsp_out, 3);
        tick();
        chk("single_ops_done_c3", {16'd0, ops_done}, 1);
        chk("single_idle_c3", {31'd0, busy}, 0);
        chk("single_ula_hold", ula_a, 1);

        // Round-robin contention after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) push(1'b0, 32'd3);
            else            push(1'b1, 32'd1);
        end
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_opcode = 5'b00000;
        req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd4; req1_opcode = 5'b00101;
        #1;
        chk("rr_first_grant0", {31'd0, req0_ready}, 1);
        accepts = 0;
        cyc = 0;
        while (accepts < 6 && cyc < 100) begin
            if (req0_ready || req1_ready) accepts++;
            tick();
            cyc++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("rr_accept_timeout", cyc < 100, 1);
        drain();
        chk("rr_ops_done", {16'd0, ops_done}, 6);

        // Backpressure on requester 1, requester 0 waits behind it
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_opcode = 5'b10001;
        push(1'b1, 32'd1);
        #1;
        chk("bp_req1_ready", {31'd0, req1_ready}, 1);
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h8000_0002; req0_b = 32'hFFFF_FFFE; req0_opcode = 5'b11111;
        push(1'b0, 32'd1);
        #1;
        chk("bp_req0_blocked_exec", {31'd0, req0_ready}, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp1_valid", {31'd0, rsp1_valid}, 1);
            chk("bp_rsp_out_stable", rsp_out, 1);
            chk("bp_req0_blocked", {31'd0, req0_ready}, 0);
            chk("bp_ops_hold", {16'd0, ops_done}, 6);
            tick();
        end
        rsp1_ready = 1'b1;
        #1;
        chk("bp_no_accept_at_rsp", {31'd0, req0_ready}, 0);
        tick();
        chk("bp_req0_after", {31'd0, req0_ready}, 1);
        tick();
        req0_valid = 1'b0;
        drain();
        chk("bp_ops_done", {16'd0, ops_done}, 8);

        // Reset while a response is pending
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_opcode = 5'b00000;
        #1;
        tick();
        req0_valid = 1'b0;
        tick();
        chk("mid_rsp0_valid", {31'd0, rsp0_valid}, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valids", {30'd0, rsp0_valid, rsp1_valid}, 0);
        chk("mid_rst_rsp_out", rsp_out, 0);
        chk("mid_rst_ops_done", {16'd0, ops_done}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        rsp0_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_opcode = 5'b00000;
        req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd4; req1_opcode = 5'b00101;
        #1;
        chk("mid_grant0", {31'd0, req0_ready}, 1);
        chk("mid_no_grant1", {31'd0, req1_ready}, 0);
        req1_valid = 1'b0;
        push(1'b0, 32'd3);
        tick();
        req0_valid = 1'b0;
        drain();
        chk("mid_ops_done", {16'd0, ops_done}, 1);

        // ops_done wrap, preloaded near the top
        force dut.ops_done_q = 16'hFFFE;
        #1;
        release dut.ops_done_q;
        chk("wrap_preload", {16'd0, ops_done}, 32'h0000_FFFE);
        run_op(1'b0, 32'd7, 32'd9, 5'b00000, 32'd16);
        chk("wrap_ffff", {16'd0, ops_done}, 32'h0000_FFFF);
        run_op(1'b1, 32'd9, 32'd9, 5'b00101, 32'd0);
        chk("wrap_zero", {16'd0, ops_done}, 0);
        run_op(1'b0, 32'hF0F0_0000, 32'h0FF0_1234, 5'b01010, 32'hFF00_1234);
        chk("wrap_after", {16'd0, ops_done}, 1);
        chk("sb_empty_end", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ula_arbiter.md
Name: ula_arbiter

Overview:
- Shares the single combinational ULA (32-bit A/B, 5-bit opcode, Out, Flag) between two requesters: requester 0 is the decode/execute path and requester 1 is the address/auxiliary path.
- Round-robin arbitration; valid/ready handshake on requests and responses.
- Registers operands in front of the ULA and captures the result behind it.
- Fixed 3-state sequence per operation; sits between the requesters and the ULA instance in the processor datapath.

Parameters:
- WIDTH, 32, operand/result width; must match the ULA.
- OPW, 5, opcode width; must match the ULA.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  input  WIDTH  requester 0 operands.
- req0_opcode  input  OPW  requester 0 ULA opcode.
- rsp0_valid  output  1  result for requester 0 available.
- rsp0_ready  input  1  requester 0 consumes result.
- req1_valid, req1_ready, req1_a, req1_b, req1_opcode, rsp1_valid, rsp1_ready: same as above, for requester 1.
- rsp_out  output  WIDTH  captured ULA Out; shared by both responses.
- rsp_flag  output  1  captured ULA Flag.
- ula_a, ula_b  output  WIDTH  registered operands to the ULA.
- ula_opcode  output  OPW  registered opcode to the ULA.
- ula_out  input  WIDTH  ULA Out (combinational).
- ula_flag  input  1  ULA Flag.
- busy  output  1  high in EXEC or RESP.
- ops_done  output  16  count of completed responses; wraps 0xFFFF -> 0.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant logic is combinational: reqN_ready = (state==IDLE) && grant==N && reqN_valid.
  - Only one ready may be high per cycle.
  - On accept, register a/b/opcode into ula_a/ula_b/ula_opcode, record owner=N, set last=N, go to EXEC.
- Arbitration:
  - Only one valid: grant that requester.
  - Both valid: grant the requester != last.
  - last resets to 1, so requester 0 wins the first contention.
- EXEC (exactly 1 cycle): the ULA settles on the registered inputs. At the clock edge, capture ula_out -> rsp_out and ula_flag -> rsp_flag, then go to RESP.
- RESP:
  - rsp<owner>_valid=1; the other rsp valid stays 0.
  - Hold rsp_out/rsp_flag stable.
  - When rsp<owner>_ready=1: go to IDLE and increment ops_done.
  - No limit on backpressure duration.
- Latency: accept at edge T, result captured at T+1, rsp valid from cycle T+2. Minimum 3 cycles per operation. The next accept is possible in the cycle after the response handshake (no accept in the same cycle as the response).
- Requests arriving while busy: reqN_ready stays 0. The requester must hold valid and operands stable until ready; the arbiter does not buffer.
- Requester drops valid before grant: no effect, nothing latched.
- ula_* outputs change only on accept and hold their last value otherwise.
- Reset values (synchronous rst=1 on any edge, including mid-EXEC/RESP):
  - State IDLE; in-flight operation discarded; no response issued.
  - ula_a=0, ula_b=0, ula_opcode=0, rsp_out=0, rsp_flag=0, ops_done=0, last=1.
  - All ready/valid outputs 0; busy=0.
  - rst has priority over every handshake in the same cycle.
- Width rules: no arithmetic on operands; values pass unmodified between ports and the ULA. Only ops_done increments (16-bit, wraps).

Test Plan:
- Single op: req0 a=1, b=2, opcode=00000 (add) -> req0_ready in cycle 0; ula_a=1/ula_b=2 in cycle 1; rsp0_valid in cycle 2 with rsp_out=3; with rsp0_ready=1, ops_done=1 and state back to IDLE in cycle 3.
- Contention round-robin: both valid continuously after reset. req0 is add 1+2, req1 is opcode 00101 with a=5, b=4. Responses arrive in the order req0 (3), req1 (1), req0 (3), alternating, with no starvation over 6 ops.
- Backpressure: req1 opcode 10001, a=1, b=1; hold rsp1_ready=0 for 5 cycles. rsp1_valid stays high with rsp_out=1 stable; req0_ready stays 0 throughout; completion happens only after rsp1_ready=1.
- Opcode 11111 with a=0x80000002, b=0xFFFFFFFE -> rsp_out=1; rsp_flag equals the ULA Flag sampled in EXEC.
- Reset mid-RESP: assert rst for 1 cycle while rsp0_valid=1. The next cycle shows all valids 0, rsp_out=0, ops_done=0. A subsequent simultaneous request grants req0 first.
- ops_done wrap: preload via 65536 completed ops (or force) -> 0xFFFF followed by 0x0000; no effect on handshakes.
